// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: opcode, forwarding-select and EX control types shared by the ID/EX operand controller
package pipe_ctrl_pkg;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef struct packed {
    logic alusrc;
    logic memread;
    logic memwrite;
    logic regwrite;
  } ex_ctrl_t;
endpackage

// File: rtl/id_ex_operand_ctrl_decode.sv
// opcode_decode: maps an RV64 opcode to EX control bits and which source registers it reads
module opcode_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ex_ctrl_t   ctrl,
  output logic       use_rs1,
  output logic       use_rs2
);
  // unknown opcodes fall through to all-zero, i.e. a NOP
  always_comb begin
    ctrl = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_OP, OP_OP32: begin
        ctrl.regwrite = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_IMM32, OP_JALR: begin
        ctrl.alusrc = 1'b1;
        ctrl.regwrite = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.alusrc = 1'b1;
        ctrl.memread = 1'b1;
        ctrl.regwrite = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.alusrc = 1'b1;
        ctrl.memwrite = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        ctrl.alusrc = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/id_ex_operand_ctrl.sv
// id_ex_operand_ctrl: ID/EX control register, hazard stall and EX forwarding selects (OPERAND_FWD_EN enables forwarding + load-use-only stalls)
module id_ex_operand_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regwrite,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        ex_fwd_a,
  output logic [1:0]        ex_fwd_b
);
  if (XLEN < 32) begin : g_xlen_too_small
  end
  ex_ctrl_t dec_ctrl, id_ctrl, ex_ctrl;
  logic use_rs1, use_rs2, hit_ex, hazard, load;
  opcode_decode u_dec (
    .opcode (id_opcode),
    .ctrl   (dec_ctrl),
    .use_rs1(use_rs1),
    .use_rs2(use_rs2)
  );
  // writes to x0 are architecturally discarded, so they never count as a producer
  always_comb begin
    id_ctrl = dec_ctrl;
    id_ctrl.regwrite = dec_ctrl.regwrite & (id_rd != '0);
  end
  assign hit_ex = id_valid & ((use_rs1 & (id_rs1 == ex_rd)) | (use_rs2 & (id_rs2 == ex_rd)));
`ifdef OPERAND_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic mw,
                                         input logic [REG_AW-1:0] md, input logic ww,
                                         input logic [REG_AW-1:0] wd);
    return (mw && md != '0 && md == rs) ? FWD_MEM : (ww && wd != '0 && wd == rs) ? FWD_WB : FWD_RF;
  endfunction
  assign hazard = hit_ex & ex_valid & ex_ctrl.memread & (ex_rd != '0);
  assign ex_fwd_a = fwd_sel(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
  assign ex_fwd_b = fwd_sel(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
`else
  logic hit_mem, unused_wb;
  assign hit_mem = id_valid & ((use_rs1 & (id_rs1 == mem_rd)) | (use_rs2 & (id_rs2 == mem_rd)));
  assign hazard = (hit_ex & ex_valid & ex_ctrl.regwrite & (ex_rd != '0)) |
                  (hit_mem & mem_regwrite & (mem_rd != '0));
  assign ex_fwd_a = FWD_RF;
  assign ex_fwd_b = FWD_RF;
  assign unused_wb = ^{wb_regwrite, wb_rd};
`endif
  assign stall = hazard & ~flush;
  assign load = id_valid & ~flush & ~stall;
  // flush and stall both leave a bubble; only a live, unstalled instruction enters EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rd <= '0;
    end else begin
      ex_valid <= load;
      ex_ctrl <= load ? id_ctrl : '0;
      ex_rs1 <= load ? id_rs1 : '0;
      ex_rs2 <= load ? id_rs2 : '0;
      ex_rd <= load ? id_rd : '0;
    end
  end
  assign ex_alusrc = ex_ctrl.alusrc;
  assign ex_memread = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_regwrite = ex_ctrl.regwrite;
endmodule

// File: tb/tb_id_ex_operand_ctrl.sv
// tb_id_ex_operand_ctrl: directed and random checks of id_ex_operand_ctrl against a reference pipeline model
`define CHK(t, o, e) check(t, 32'(o), 32'(e))
module tb_id_ex_operand_ctrl;
`ifdef OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, flush = 1'b0;
  logic mem_regwrite = 1'b0, wb_regwrite = 1'b0;
  logic [6:0] id_opcode = '0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0, mem_rd = '0, wb_rd = '0;
  logic stall, ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [1:0] ex_fwd_a, ex_fwd_b;
  int n_cmp = 0, n_bad = 0;
  logic m_v = 0, m_as = 0, m_mr = 0, m_mw = 0, m_rw = 0;
  logic [4:0] m_rs1 = 0, m_rs2 = 0, m_rd = 0;
  logic p_mw = 0, p_ww = 0;
  logic [4:0] p_md = 0, p_wd = 0;
  logic [6:0] ops [11] = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6f, 7'h37, 7'h17};

  id_ex_operand_ctrl #(.XLEN(64), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .stall(stall), .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] dec(input logic [6:0] op);
    case (op)
      7'h33, 7'h3b: return 6'b000111;
      7'h13, 7'h1b, 7'h67: return 6'b100110;
      7'h03: return 6'b110110;
      7'h23: return 6'b101011;
      7'h63: return 6'b000011;
      7'h6f, 7'h37, 7'h17: return 6'b100100;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic reads(input logic [5:0] d, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] x);
    return (d[1] && r1 == x) || (d[0] && r2 == x);
  endfunction

  function automatic logic [1:0] sel(input logic [4:0] rs, input logic mw, input logic [4:0] md,
                                     input logic ww, input logic [4:0] wd);
    if (!FWD) return 2'd0;
    if (mw && md != 0 && md == rs) return 2'd2;
    if (ww && wd != 0 && wd == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic step(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic fl, input logic mw, input logic [4:0] md,
                      input logic ww, input logic [4:0] wd, output logic st);
    logic [5:0] d;
    logic hz, ld;
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; flush = fl;
    mem_regwrite = mw; mem_rd = md; wb_regwrite = ww; wb_rd = wd;
    #4;
    d = dec(op);
    if (FWD) hz = v && m_v && m_mr && m_rd != 0 && reads(d, r1, r2, m_rd);
    else hz = v && ((m_v && m_rw && m_rd != 0 && reads(d, r1, r2, m_rd)) || (mw && md != 0 && reads(d, r1, r2, md)));
    st = hz && !fl;
    `CHK("stall", stall, st);
    if (m_v) begin
      `CHK("fwd_a", ex_fwd_a, sel(m_rs1, mw, md, ww, wd));
      `CHK("fwd_b", ex_fwd_b, sel(m_rs2, mw, md, ww, wd));
    end
    @(posedge clk);
    p_ww = p_mw; p_wd = p_md; p_mw = m_v && m_rw; p_md = m_rd;
    ld = v && !fl && !st;
    m_v = ld;
    {m_as, m_mr, m_mw, m_rw} = ld ? {d[5:3], d[2] && rd != 0} : 4'b0;
    m_rs1 = r1; m_rs2 = r2; m_rd = rd;
    #1;
    `CHK("ex_valid", ex_valid, m_v);
    `CHK("ex_alusrc", ex_alusrc, m_as);
    `CHK("ex_memread", ex_memread, m_mr);
    `CHK("ex_memwrite", ex_memwrite, m_mw);
    `CHK("ex_regwrite", ex_regwrite, m_rw);
    if (m_v) begin
      `CHK("ex_rs1", ex_rs1, m_rs1);
      `CHK("ex_rs2", ex_rs2, m_rs2);
      `CHK("ex_rd", ex_rd, m_rd);
    end
  endtask

  task automatic step_a(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic fl, output logic st);
    step(v, op, r1, r2, rd, fl, p_mw, p_md, p_ww, p_wd, st);
  endtask

  task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, output int n);
    logic st;
    n = 0;
    step_a(v, op, r1, r2, rd, 1'b0, st);
    while (st && n < 4) begin
      n++;
      step_a(v, op, r1, r2, rd, 1'b0, st);
    end
  endtask

  task automatic drain();
    int n;
    repeat (3) issue(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, n);
  endtask

  task automatic pipe_in();
    mem_regwrite = p_mw; mem_rd = p_md; wb_regwrite = p_ww; wb_rd = p_wd;
    #1;
  endtask

  initial begin
    int n;
    logic st;
    #1;
    `CHK("rst_stall", stall, 0);
    `CHK("rst_valid", ex_valid, 0);
    `CHK("rst_regwrite", ex_regwrite, 0);
    `CHK("rst_fwd_a", ex_fwd_a, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b1, 7'h13, 5'd0, 5'd0, 5'd1, n);
    `CHK("addi_alusrc", ex_alusrc, 1);
    `CHK("addi_regwrite", ex_regwrite, 1);
    drain();

    issue(1'b1, 7'h03, 5'd1, 5'd0, 5'd5, n);
    issue(1'b1, 7'h33, 5'd5, 5'd7, 5'd6, n);
    `CHK("ldu_stall_cycles", n, FWD ? 1 : 2);
    pipe_in();
    `CHK("ldu_fwd_a", ex_fwd_a, FWD ? 1 : 0);
    drain();

    issue(1'b1, 7'h33, 5'd1, 5'd2, 5'd3, n);
    issue(1'b1, 7'h33, 5'd3, 5'd3, 5'd4, n);
    `CHK("raw_stall_cycles", n, FWD ? 0 : 2);
    pipe_in();
    `CHK("raw_fwd_a", ex_fwd_a, FWD ? 2 : 0);
    `CHK("raw_fwd_b", ex_fwd_b, FWD ? 2 : 0);
    drain();

    step(1'b1, 7'h33, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, st);
    id_valid = 1'b0; mem_regwrite = 1'b1; mem_rd = 5'd8; wb_regwrite = 1'b1; wb_rd = 5'd8;
    #1;
    `CHK("mem_prio_a", ex_fwd_a, FWD ? 2 : 0);
    `CHK("mem_prio_b", ex_fwd_b, FWD ? 2 : 0);
    mem_regwrite = 1'b0;
    #1;
    `CHK("wb_only_a", ex_fwd_a, FWD ? 1 : 0);
    step(1'b1, 7'h33, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, st);
    id_valid = 1'b0; mem_regwrite = 1'b1; mem_rd = 5'd0; wb_regwrite = 1'b1; wb_rd = 5'd0;
    #1;
    `CHK("x0_sel_a", ex_fwd_a, 0);
    `CHK("x0_sel_b", ex_fwd_b, 0);
    drain();

    issue(1'b1, 7'h03, 5'd1, 5'd0, 5'd5, n);
    id_valid = 1'b1; id_opcode = 7'h33; id_rs1 = 5'd5; id_rs2 = 5'd7; id_rd = 5'd6; flush = 1'b1;
    pipe_in();
    `CHK("flush_stall", stall, 0);
    step_a(1'b1, 7'h33, 5'd5, 5'd7, 5'd6, 1'b1, st);
    `CHK("flush_bubble", ex_valid, 0);
    drain();

    issue(1'b1, 7'h03, 5'd1, 5'd0, 5'd5, n);
    id_valid = 1'b1; id_opcode = 7'h33; id_rs1 = 5'd5; id_rs2 = 5'd7; id_rd = 5'd6; flush = 1'b0;
    pipe_in();
    `CHK("pre_rst_stall", stall, 1);
    rst_n = 1'b0;
    #1;
    `CHK("mid_rst_stall", stall, 0);
    `CHK("mid_rst_valid", ex_valid, 0);
    `CHK("mid_rst_memread", ex_memread, 0);
    `CHK("mid_rst_alusrc", ex_alusrc, 0);
    `CHK("mid_rst_rd", ex_rd, 0);
    `CHK("mid_rst_rs1", ex_rs1, 0);
    `CHK("mid_rst_fwd_a", ex_fwd_a, 0);
    m_v = 0; {m_as, m_mr, m_mw, m_rw} = 4'b0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    p_mw = 0; p_md = 0; p_ww = 0; p_wd = 0;
    id_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 7'h13, 5'd0, 5'd0, 5'd1, n);
    `CHK("post_rst_stall_cycles", n, 0);
    `CHK("post_rst_regwrite", ex_regwrite, 1);

    repeat (400) begin
      int k;
      logic [6:0] op;
      k = $urandom_range(0, 12);
      op = (k < 11) ? ops[k] : 7'($urandom);
      step($urandom_range(0, 9) != 0, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
           1'($urandom), 5'($urandom_range(0, 7)), st);
      n_cmp += 2;
      if (ex_valid !== m_v) begin
        n_bad++;
        $error("FAIL rnd_ex_valid observed=%0h expected=%0h", ex_valid, m_v);
      end
      if (ex_regwrite !== m_rw) begin
        n_bad++;
        $error("FAIL rnd_ex_regwrite observed=%0h expected=%0h", ex_regwrite, m_rw);
      end
      mem_regwrite = p_mw; mem_rd = p_md; wb_regwrite = p_ww; wb_rd = p_wd; id_valid = 1'b0;
      #1;
      n_cmp += 2;
      if (stall !== 1'b0) begin
        n_bad++;
        $error("FAIL rnd_idle_stall observed=%0h expected=0", stall);
      end
      if (ex_fwd_a !== (m_v ? sel(m_rs1, p_mw, p_md, p_ww, p_wd) : ex_fwd_a)) begin
        n_bad++;
        $error("FAIL rnd_fwd_a observed=%0h", ex_fwd_a);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    if (n_bad != 0) $display("FAIL: %0d mismatches", n_bad);
    else $display("PASS");
    $finish;
  end
endmodule
